// File: rtl/fetch_seq_pkg.sv
// rtl/fetch_seq_pkg.sv - shared types and constants for the fetch sequencer
package fetch_seq_pkg;

  typedef enum logic [2:0] {
    ST_FETCH_HI,
    ST_FETCH_LO,
    ST_DATA,
    ST_EXEC,
    ST_HALTED
  } state_e;

  typedef enum logic [1:0] {
    ADDR_PC,
    ADDR_PC1,
    ADDR_DP
  } addr_sel_e;

  localparam logic [7:0]  OPC_HALT = 8'h01;
  localparam logic [7:0]  OPC_TRAP = 8'h02;
  localparam logic [15:0] SRC_MASK = 16'hC600;
  localparam logic [15:0] SRC_DATA = 16'h8200;

  function automatic logic is_data_src(input logic [15:0] word);
    return (word & SRC_MASK) == SRC_DATA;
  endfunction

  function automatic logic [15:0] inst_len(input logic [15:0] word);
    return word[15] ? 16'd2 : 16'd1;
  endfunction

  function automatic logic is_fetch_state(input state_e st);
    return (st == ST_FETCH_HI) || (st == ST_FETCH_LO) || (st == ST_DATA);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - byte-wide memory read port between sequencer and memory
interface fetch_sequencer_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/fetch_sequencer_operand_addr_gen.sv
// rtl/fetch_sequencer_operand_addr_gen.sv - memory address mux over pc, pc+1 and dp+offset
module operand_addr_gen
  import fetch_seq_pkg::*;
(
  input  addr_sel_e   sel_i,
  input  logic [15:0] pc_i,
  input  logic [15:0] dp_i,
  input  logic [7:0]  offset_i,
  output logic [15:0] addr_o
);
  logic [15:0] pc_inc;
  logic [15:0] dp_off;

  // Both sums wrap mod 2^16, so pc=FFFF fetches its low byte from 0000.
  assign pc_inc = pc_i + 16'd1;
  assign dp_off = dp_i + {8'h00, offset_i};

  always_comb begin
    addr_o = pc_i;
    case (sel_i)
      ADDR_PC:  addr_o = pc_i;
      ADDR_PC1: addr_o = pc_inc;
      ADDR_DP:  addr_o = dp_off;
      default:  addr_o = pc_i;
    endcase
  end
endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch/execute sequencer owning PC, halt and trap flow
// FETCH_SEQ_SINGLE_STEP_EN adds a step input and parks in HALTED after every executed instruction.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] TRAP_VECTOR = 16'h0004
) (
  input  logic              clk,
  input  logic              rst,
  fetch_sequencer_if.master mem,
  input  logic [15:0]       dp,
  output logic [15:0]       inst,
  output logic [7:0]        data,
  output logic              dec_en,
  input  logic              exec_busy,
  input  logic              pc_load,
  input  logic [15:0]       pc_target,
  output logic [15:0]       pc,
  input  logic              run,
  output logic              halted,
  output logic              trap_pulse
`ifdef FETCH_SEQ_SINGLE_STEP_EN
  ,
  input  logic              step
`endif
);
  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] inst_q, inst_d;
  logic [7:0]  data_q, data_d;
  logic        trap_q, trap_d;
  logic        req_q;
  logic        dec_en_q;
  logic        halted_q;
  logic        xfer;
  logic        resume;
  addr_sel_e   addr_sel;
  logic [15:0] addr_raw;

`ifdef FETCH_SEQ_SINGLE_STEP_EN
  localparam bit STEP_MODE = 1'b1;
  assign resume = run | step;
`else
  localparam bit STEP_MODE = 1'b0;
  assign resume = run;
`endif

  // An ack only counts while a request is actually outstanding.
  assign xfer = req_q & mem.mem_ack;

  always_comb begin
    case (state_q)
      ST_FETCH_LO: addr_sel = ADDR_PC1;
      ST_DATA:     addr_sel = ADDR_DP;
      default:     addr_sel = ADDR_PC;
    endcase
  end

  operand_addr_gen u_addr_gen (
    .sel_i    (addr_sel),
    .pc_i     (pc_q),
    .dp_i     (dp),
    .offset_i (inst_q[7:0]),
    .addr_o   (addr_raw)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    data_d  = data_q;
    trap_d  = 1'b0;
    case (state_q)
      ST_FETCH_HI: begin
        if (xfer) begin
          inst_d  = {mem.mem_rdata, 8'h00};
          state_d = mem.mem_rdata[7] ? ST_FETCH_LO : ST_EXEC;
        end
      end
      ST_FETCH_LO: begin
        if (xfer) begin
          inst_d  = {inst_q[15:8], mem.mem_rdata};
          state_d = is_data_src({inst_q[15:8], mem.mem_rdata}) ? ST_DATA : ST_EXEC;
        end
      end
      ST_DATA: begin
        if (xfer) begin
          data_d  = mem.mem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Halt and trap outrank pc_load; pc_load outranks the sequential step.
        if (!exec_busy) begin
          if (inst_q[15:8] == OPC_HALT) begin
            pc_d    = pc_q + 16'd1;
            state_d = ST_HALTED;
          end else if (inst_q[15:8] == OPC_TRAP) begin
            pc_d    = TRAP_VECTOR;
            trap_d  = 1'b1;
            state_d = ST_FETCH_HI;
          end else begin
            pc_d    = pc_load ? pc_target : pc_q + inst_len(inst_q);
            state_d = STEP_MODE ? ST_HALTED : ST_FETCH_HI;
          end
        end
      end
      ST_HALTED: begin
        if (resume) begin
          state_d = ST_FETCH_HI;
        end
      end
      default: state_d = ST_FETCH_HI;
    endcase
  end

  // Outputs are registered from the next state, so reset forces them all low at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_FETCH_HI;
      pc_q     <= RESET_PC;
      inst_q   <= 16'h0000;
      data_q   <= 8'h00;
      trap_q   <= 1'b0;
      req_q    <= 1'b0;
      dec_en_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      data_q   <= data_d;
      trap_q   <= trap_d;
      req_q    <= is_fetch_state(state_d);
      dec_en_q <= (state_d == ST_EXEC);
      halted_q <= (state_d == ST_HALTED);
    end
  end

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = req_q ? addr_raw : 16'h0000;
  assign inst         = inst_q;
  assign data         = data_q;
  assign dec_en       = dec_en_q;
  assign pc           = pc_q;
  assign halted       = halted_q;
  assign trap_pulse   = trap_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] dp;
  logic [15:0] inst;
  logic [7:0]  data;
  logic        dec_en;
  logic        exec_busy;
  logic        pc_load;
  logic [15:0] pc_target;
  logic [15:0] pc;
  logic        run;
  logic        halted;
  logic        trap_pulse;
  logic        step;

  int checks   = 0;
  int failures = 0;
  int wait_states = 0;
  int wcnt = 0;
  int trap_cnt = 0;
  int unstable_cnt = 0;
  logic        prev_wait = 1'b0;
  logic [15:0] prev_addr = 16'h0000;
  logic [7:0]  mem [0:65535];
  logic [15:0] addr_log [$];

  fetch_sequencer_if mif ();

  fetch_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .mem        (mif),
    .dp         (dp),
    .inst       (inst),
    .data       (data),
    .dec_en     (dec_en),
    .exec_busy  (exec_busy),
    .pc_load    (pc_load),
    .pc_target  (pc_target),
    .pc         (pc),
    .run        (run),
    .halted     (halted),
    .trap_pulse (trap_pulse)
`ifdef FETCH_SEQ_SINGLE_STEP_EN
    ,
    .step       (step)
`endif
  );

  always #5 clk = ~clk;

  assign mif.mem_ack   = mif.mem_req && (wcnt >= wait_states);
  assign mif.mem_rdata = mem[mif.mem_addr];

  always @(posedge clk) begin
    if (mif.mem_req && !mif.mem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (mif.mem_req && mif.mem_ack) addr_log.push_back(mif.mem_addr);
  end

  always @(negedge clk) begin
    if (trap_pulse) trap_cnt++;
    if (prev_wait && mif.mem_req && (mif.mem_addr != prev_addr)) unstable_cnt++;
    prev_wait = mif.mem_req && !mif.mem_ack;
    prev_addr = mif.mem_addr;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Starts at a negedge in FETCH_HI; returns at the first negedge after EXEC.
  task automatic exec_one(input int busy_n, output int cyc, output int ex_cyc,
                          output logic [15:0] ins, output logic [7:0] dat);
    cyc = 0;
    ex_cyc = 0;
    while (!dec_en && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    ins = inst;
    dat = data;
    while (dec_en && cyc < 40) begin
      ex_cyc++;
      exec_busy = (ex_cyc <= busy_n);
      @(negedge clk);
      cyc++;
    end
    exec_busy = 1'b0;
    if (cyc >= 40) check("exec_timeout", cyc, 0);
  endtask

  task automatic wait_halted(input string tag);
    int n = 0;
    while (!halted && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) check(tag, halted, 1);
  endtask

  initial begin
    int cyc, ex_cyc, nreq;
    logic [15:0] ins;
    logic [7:0]  dat;

    rst = 1'b1; dp = 16'h0000; exec_busy = 1'b0; pc_load = 1'b0;
    pc_target = 16'h0000; run = 1'b0; step = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0010] = 8'h88; mem[16'h0011] = 8'h05;
    mem[16'h0020] = 8'h82; mem[16'h0021] = 8'h03; mem[16'h0103] = 8'hAB;
    mem[16'h0022] = 8'h88; mem[16'h0023] = 8'h11;
    mem[16'h0040] = 8'h02;
    mem[16'h0030] = 8'h01;
    mem[16'h0031] = 8'h88; mem[16'h0032] = 8'h22;
    mem[16'hFFFF] = 8'h88;

    repeat (3) @(negedge clk);
    check("rst_mem_req", mif.mem_req, 0);
    check("rst_pc", pc, 16'h0000);
    check("rst_inst", inst, 16'h0000);
    check("rst_data", data, 8'h00);
    check("rst_dec_en", dec_en, 0);
    check("rst_halted", halted, 0);
    check("rst_trap", trap_pulse, 0);
    rst = 1'b0;
    @(negedge clk);
    check("first_req", mif.mem_req, 1);
    check("first_addr", mif.mem_addr, 16'h0000);

`ifndef FETCH_SEQ_SINGLE_STEP_EN
    exec_one(0, cyc, ex_cyc, ins, dat);
    check("nop_cycles", cyc, 2);
    check("nop_dec_cycles", ex_cyc, 1);
    check("nop_inst", ins, 16'h0000);
    check("nop_pc", pc, 16'h0001);

    pc_load = 1'b1; pc_target = 16'h0010;
    exec_one(0, cyc, ex_cyc, ins, dat);
    check("jmp10_pc", pc, 16'h0010);
    pc_load = 1'b0;

    addr_log.delete();
    exec_one(0, cyc, ex_cyc, ins, dat);
    check("imm_cycles", cyc, 3);
    check("imm_inst", ins, 16'h8805);
    check("imm_nbytes", addr_log.size(), 2);
    check("imm_addr1", addr_log[1], 16'h0011);
    check("imm_pc", pc, 16'h0012);

    pc_load = 1'b1; pc_target = 16'h0020;
    exec_one(0, cyc, ex_cyc, ins, dat);
    pc_load = 1'b0; dp = 16'h0100;
    check("jmp20_pc", pc, 16'h0020);

    addr_log.delete();
    exec_one(0, cyc, ex_cyc, ins, dat);
    check("ds_cycles", cyc, 4);
    check("ds_inst", ins, 16'h8203);
    check("ds_data", dat, 8'hAB);
    check("ds_nbytes", addr_log.size(), 3);
    check("ds_addr0", addr_log[0], 16'h0020);
    check("ds_addr1", addr_log[1], 16'h0021);
    check("ds_addr2", addr_log[2], 16'h0103);
    check("ds_pc", pc, 16'h0022);

    pc_load = 1'b1; pc_target = 16'h0040;
    exec_one(0, cyc, ex_cyc, ins, dat);
    check("load_cycles", cyc, 3);
    check("data_retained", dat, 8'hAB);
    check("load_pc", pc, 16'h0040);

    pc_target = 16'h0030;
    exec_one(0, cyc, ex_cyc, ins, dat);
    check("trap_pc", pc, 16'h0004);
    check("trap_pulse_hi", trap_pulse, 1);
    exec_one(0, cyc, ex_cyc, ins, dat);
    check("trap_pulse_count", trap_cnt, 1);
    check("after_trap_pc", pc, 16'h0030);

    exec_one(0, cyc, ex_cyc, ins, dat);
    pc_load = 1'b0;
    check("halt_flag", halted, 1);
    check("halt_pc", pc, 16'h0031);
    nreq = 0;
    repeat (10) begin
      @(negedge clk);
      if (mif.mem_req) nreq++;
    end
    check("halt_no_req", nreq, 0);
    check("halt_hold", halted, 1);

    wait_states = 3;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    check("run_req", mif.mem_req, 1);
    check("run_addr", mif.mem_addr, 16'h0031);
    check("run_halted", halted, 0);
    addr_log.delete();
    exec_one(2, cyc, ex_cyc, ins, dat);
    check("wait_cycles", cyc, 11);
    check("wait_exec_cycles", ex_cyc, 3);
    check("wait_inst", ins, 16'h8822);
    check("wait_addr1", addr_log[1], 16'h0032);
    check("wait_addr_stable", unstable_cnt, 0);
    check("wait_pc", pc, 16'h0033);

    @(negedge clk);
    check("pre_rst_req", mif.mem_req, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_req", mif.mem_req, 0);
    check("async_rst_pc", pc, 16'h0000);
    @(negedge clk);
    check("async_rst_inst", inst, 16'h0000);
    wait_states = 0;
    rst = 1'b0;
    @(negedge clk);
    check("rerun_addr", mif.mem_addr, 16'h0000);

    pc_load = 1'b1; pc_target = 16'hFFFF;
    exec_one(0, cyc, ex_cyc, ins, dat);
    pc_load = 1'b0;
    check("jmpffff_pc", pc, 16'hFFFF);
    addr_log.delete();
    exec_one(0, cyc, ex_cyc, ins, dat);
    check("wrap_inst", ins, 16'h8800);
    check("wrap_addr0", addr_log[0], 16'hFFFF);
    check("wrap_addr1", addr_log[1], 16'h0000);
    check("wrap_pc", pc, 16'h0001);
`else
    wait_halted("ss_first_timeout");
    check("ss_first_pc", pc, 16'h0001);
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      check("ss_left_halt", halted, 0);
      wait_halted("ss_step_timeout");
    end
    check("ss_three_steps_pc", pc, 16'h0004);
    check("ss_halted", halted, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Control FSM that sequences the 16-bit CPU's instruction cycle: fetch 1 or 2 instruction bytes over the shared 8-bit memory port, fetch the data-source operand byte when required, then strobe the decoder/execute stage.
- Owns the PC and the halt/trap control flow.
- Sits between the byte-wide memory port and the decoder + datapath; it is the only requester on the fetch side of the memory port.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- TRAP_VECTOR, 16'h0004, PC value loaded when a trap instruction executes.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- mem_req  out  1  memory read request
- mem_addr  out  16  memory byte address
- mem_rdata  in  8  read data, valid when mem_ack=1
- mem_ack  in  1  transaction complete this cycle
- dp  in  16  data pointer from datapath
- inst  out  16  assembled instruction word to decoder
- data  out  8  operand byte to decoder
- dec_en  out  1  decoder enable, high in EXEC only
- exec_busy  in  1  datapath needs more cycles; hold EXEC
- pc_load  in  1  sampled on the last EXEC cycle; take pc_target
- pc_target  in  16  branch/call/return target
- pc  out  16  current instruction address
- run  in  1  resume pulse from HALTED
- halted  out  1  high while in HALTED
- trap_pulse  out  1  one-cycle pulse when a trap executes

Behaviour:
- Reset (async, immediate):
  - State FETCH_HI; pc=RESET_PC; inst=0; data=0.
  - All outputs 0, except pc.
  - Reset mid-transaction abandons it; mem_req drops in the same cycle.
- Memory handshake:
  - mem_req is held high with mem_addr stable until mem_ack.
  - mem_ack may be high in the same cycle as the request (zero-wait, 1 cycle per byte).
  - Capture mem_rdata on the ack cycle.
  - Back-to-back requests are legal: mem_req stays high and mem_addr changes the cycle after the ack.
  - mem_ack while mem_req=0 is ignored.
- States and transitions:
  - FETCH_HI:
    - mem_addr=pc.
    - On ack: inst[15:8]=rdata; inst[7:0]=0.
    - If rdata[7]=1, go to FETCH_LO; else go to EXEC.
  - FETCH_LO:
    - mem_addr=pc+1.
    - On ack: inst[7:0]=rdata.
    - If inst[15:14]=2'b10 and inst[10:9]=2'b01 (data source), go to DATA; else go to EXEC.
  - DATA:
    - mem_addr=dp+{8'h00,inst[7:0]}, wrapping mod 2^16.
    - On ack: data=rdata; go to EXEC.
  - EXEC:
    - dec_en=1; remain while exec_busy=1.
    - On the first cycle with exec_busy=0, apply the first matching rule:
      - opcode 8'h01 (halt): pc=pc+1; go to HALTED.
      - opcode 8'h02 (trap): pc=TRAP_VECTOR; trap_pulse=1; go to FETCH_HI.
      - pc_load=1: pc=pc_target; go to FETCH_HI.
      - otherwise: pc=pc+len (len=1 if inst[15]=0, else 2), mod 2^16; go to FETCH_HI.
  - HALTED:
    - halted=1; no requests.
    - run=1 goes to FETCH_HI next cycle.
    - run in any other state is ignored.
- Boundaries:
  - pc=16'hFFFF with a 2-byte instruction fetches its low byte from 16'h0000.
  - pc_load takes priority over sequential increment, but not over halt or trap.
  - data is not cleared between instructions; it is only meaningful for data-source instructions.
- Minimum instruction latency (zero-wait memory, exec_busy=0):
  - 1-byte instruction: 2 cycles.
  - 2-byte instruction: 3 cycles.
  - Data-source instruction: 4 cycles.

Optional Feature:
- Macro: FETCH_SEQ_SINGLE_STEP_EN.
- With the macro defined:
  - Add input port step (1 bit).
  - After each EXEC completes, the FSM goes to HALTED, except when taking a trap.
  - A pulse on run or step fetches and executes exactly one instruction.
  - A halt instruction still halts.
- Without the macro: no step port; free-running as above.

Decomposition:
- Shared package fetch_seq_pkg holds:
  - State enum.
  - OPC_HALT=8'h01 and OPC_TRAP=8'h02.
  - Source-field constants: mask 16'hC600, data-source value 16'h8200.
- One natural sub-module, operand_addr_gen: combinational mem_addr mux over pc, pc+1 and dp+offset.
- Everything else stays in fetch_sequencer.

Test Plan:
- Reset, then memory at 0 holds 8'h00 (nop), zero-wait ack:
  - mem_addr=0000, then pc=0001 after 2 cycles; dec_en high for 1 cycle; inst=16'h0000.
- Memory holds 8'h88,8'h05 at pc=0010 (add imm):
  - inst=16'h8805; no DATA fetch; pc=0012 after 3 cycles.
- Data source, dp=0100, bytes 8'h82,8'h03 at pc=0020, mem[0103]=8'hAB:
  - mem_addr sequence 0020, 0021, 0103; data=AB in EXEC; pc=0022.
- pc_load with pc_target=0040:
  - pc=0040.
- Trap byte 8'h02:
  - trap_pulse=1 for 1 cycle; pc=0004.
- Halt byte 8'h01 at 0030:
  - halted=1, pc=0031, no mem_req for 10 cycles.
  - After a run pulse: fetch at 0031.
- Wait-stated ack (3 cycles) plus exec_busy for 2 cycles:
  - mem_addr stable during wait; EXEC held 3 cycles.
- Reset asserted while mem_req is high:
  - mem_req=0 in the same cycle; pc=RESET_PC.
- FETCH_SEQ_SINGLE_STEP_EN build:
  - Three step pulses advance pc by exactly three instructions.
